// File: rtl/bus_sequencer.sv
// bus_sequencer: multi-cycle bus control unit (fetch/decode/ALU/writeback strobes); define BUS_SEQ_HILO_EN for the mul/div HI/LO steps
module bus_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Csignout,
  output logic [15:0] Rout,
  output logic        MARin,
  output logic        MDRin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic        Read,
  output logic        IncPC,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;
  state_t      r_state;
  logic [4:0]  w_op;
  logic [15:0] w_ra_oh, w_rb_oh, w_rc_oh;
  logic        w_r, w_i, w_md, w_legal;
  logic        w_unused;
  assign w_op     = ir[31:27];
  assign w_ra_oh  = 16'h1 << ir[26:23];
  assign w_rb_oh  = 16'h1 << ir[22:19];
  assign w_rc_oh  = 16'h1 << ir[18:15];
  assign w_unused = ^ir[14:0];
  assign w_r      = w_op <= 5'd8;
  assign w_i      = w_op inside {[5'd9:5'd11]};
`ifdef BUS_SEQ_HILO_EN
  assign w_md     = w_op inside {5'd14, 5'd15};
`else
  assign w_md     = 1'b0;
`endif
  assign w_legal  = w_r | w_i | w_md;
  // Step sequencer; illegal opcodes bail out of decode, mul/div take the extra HI step
  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else case (r_state)
      IDLE:    r_state <= start ? T0 : IDLE;
      T0:      r_state <= T1;
      T1:      r_state <= T2;
      T2:      r_state <= T3;
      T3:      r_state <= w_legal ? T4 : IDLE;
      T4:      r_state <= T5;
      T5:      r_state <= w_md ? T6 : DONE;
      T6:      r_state <= DONE;
      default: r_state <= IDLE;
    endcase
  end
  // Bus source enables: one driver per step, register fields picked from the IR
  always_comb begin
    PCout    = r_state == T0;
    MDRout   = r_state == T2;
    Zlowout  = r_state inside {T1, T5};
    Csignout = r_state == T4 && w_i;
    Rout     = (r_state == T3 && (w_r || w_i)) ? w_rb_oh :
               (r_state == T3 && w_md)         ? w_ra_oh :
               (r_state == T4 && w_r)          ? w_rc_oh :
               (r_state == T4 && w_md)         ? w_rb_oh : '0;
  end
  // Destination loads, memory/PC control and ALU operation
  always_comb begin
    MARin  = r_state == T0;
    IncPC  = r_state == T0;
    PCin   = r_state == T1;
    Read   = r_state == T1;
    MDRin  = r_state == T1;
    IRin   = r_state == T2;
    Yin    = r_state == T3 && w_legal;
    Zin    = r_state inside {T0, T4};
    Rin    = (r_state == T5 && !w_md) ? w_ra_oh : '0;
    alu_op = r_state != T4 ? 5'd0 :
             !w_i          ? w_op :
             w_op == 5'd9  ? 5'd0 :
             w_op == 5'd10 ? 5'd2 : 5'd3;
  end
`ifdef BUS_SEQ_HILO_EN
  // 64-bit product/quotient: low word in T5, high word in T6
  always_comb begin
    LOin     = r_state == T5 && w_md;
    Zhighout = r_state == T6;
    HIin     = r_state == T6;
  end
`else
  assign LOin     = 1'b0;
  assign Zhighout = 1'b0;
  assign HIin     = 1'b0;
`endif
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign err  = r_state == T3 && !w_legal;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: randomized self-checking bench against a microprogram-table model
module tb_bus_sequencer;
  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] ir;
  logic        PCout, MDRout, Zhighout, Zlowout, Csignout;
  logic [15:0] Rout, Rin;
  logic        MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, Read, IncPC;
  logic [4:0]  alu_op;
  logic        busy, done, err;
  typedef struct packed {
    logic pc_out, mdr_out, zh_out, zl_out, cs_out;
    logic [15:0] r_out;
    logic mar_in, mdr_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic [15:0] r_in;
    logic rd, inc_pc;
    logic [4:0] alu;
    logic busy, done, err;
  } obs_t;
  obs_t got;
  obs_t exp_q[$];
  int   n_err = 0, n_chk = 0, cyc = 0, prev_t0 = -1, prev_lat = 0;
  int   lat_tab [4] = '{7, 7, 8, 4};
  int   imm_alu [9:11] = '{0, 2, 3};
  bus_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .Csignout(Csignout),
    .Rout(Rout), .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Read(Read), .IncPC(IncPC), .alu_op(alu_op),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    got = '0;
    got.pc_out = PCout; got.mdr_out = MDRout; got.zh_out = Zhighout; got.zl_out = Zlowout;
    got.cs_out = Csignout; got.r_out = Rout; got.mar_in = MARin; got.mdr_in = MDRin;
    got.pc_in = PCin; got.ir_in = IRin; got.y_in = Yin; got.z_in = Zin; got.hi_in = HIin;
    got.lo_in = LOin; got.r_in = Rin; got.rd = Read; got.inc_pc = IncPC; got.alu = alu_op;
    got.busy = busy; got.done = done; got.err = err;
  end
  task automatic check(input string tag, input logic [63:0] g, input logic [63:0] e);
    n_chk++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, g, e);
    end
  endtask
  task automatic cyc_check(input string tag, input obs_t e);
    check(tag, 64'(got), 64'(e));
    check({tag, "_src"}, 64'($countones({PCout, MDRout, Zhighout, Zlowout, Csignout, Rout}) <= 1), 64'd1);
    check({tag, "_1hot"}, 64'($onehot0(Rin) && $onehot0(Rout)), 64'd1);
  endtask
  // Instruction class: 0 R-type, 1 I-type, 2 mul/div, 3 illegal
  function automatic int kind(input logic [4:0] op);
    if (op <= 5'd8) return 0;
    if (op <= 5'd11) return 1;
`ifdef BUS_SEQ_HILO_EN
    if (op == 5'd14 || op == 5'd15) return 2;
`endif
    return 3;
  endfunction
  // Expected per-cycle strobes for one instruction, T0 through its last step
  function automatic void build(input logic [31:0] x);
    int c;
    obs_t e;
    logic [15:0] ra, rb, rc;
    c = kind(x[31:27]);
    ra = 16'h1 << x[26:23];
    rb = 16'h1 << x[22:19];
    rc = 16'h1 << x[18:15];
    exp_q.delete();
    e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; exp_q.push_back(e);
    e = '0; e.busy = 1; e.zl_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1; exp_q.push_back(e);
    e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1; exp_q.push_back(e);
    e = '0; e.busy = 1;
    if (c == 3) begin
      e.err = 1; exp_q.push_back(e);
      return;
    end
    e.y_in = 1; e.r_out = (c == 2) ? ra : rb; exp_q.push_back(e);
    e = '0; e.busy = 1; e.z_in = 1;
    e.alu = (c == 1) ? 5'(imm_alu[x[31:27]]) : x[31:27];
    if (c == 0) e.r_out = rc;
    else if (c == 1) e.cs_out = 1;
    else e.r_out = rb;
    exp_q.push_back(e);
    e = '0; e.busy = 1; e.zl_out = 1;
    if (c == 2) e.lo_in = 1; else e.r_in = ra;
    exp_q.push_back(e);
    if (c == 2) begin
      e = '0; e.busy = 1; e.zh_out = 1; e.hi_in = 1; exp_q.push_back(e);
    end
    e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
  endfunction
  function automatic logic [31:0] rand_instr();
    int r;
    logic [4:0] op;
    r = $urandom_range(0, 9);
    op = (r < 5) ? 5'($urandom_range(0, 11)) : (r < 8) ? 5'(14 + r % 2) : 5'($urandom);
    return {op, 27'($urandom)};
  endfunction
  // Issue one instruction from IDLE; abort_k >= 0 pulses clr during that step
  task automatic run(input logic [31:0] x, input bit hold, input int abort_k);
    int k_end, t0;
    obs_t z;
    z = '0;
    k_end = 0;
    build(x);
    ir = $urandom;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    if (hold && prev_t0 >= 0) check("span", 64'(t0 - prev_t0), 64'(prev_lat + 1));
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc_check($sformatf("op%0d_step%0d", x[31:27], k), exp_q[k]);
      if (got.done || got.err) k_end = k + 1;
      if (k == abort_k) begin
        clr = 1;
        start = 1;
        @(negedge clk);
        cyc_check("abort", z);
        clr = 0;
        start = 0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          cyc_check("post_abort", z);
        end
        prev_t0 = -1;
        return;
      end
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == 2) ir = x;
      @(negedge clk);
    end
    check($sformatf("latency_op%0d", x[31:27]), 64'(k_end), 64'(lat_tab[kind(x[31:27])]));
    cyc_check("idle_after", z);
    start = hold;
    prev_t0 = hold ? t0 : -1;
    prev_lat = lat_tab[kind(x[31:27])];
  endtask
  initial begin
    obs_t z;
    z = '0;
    clr = 1;
    start = 1;
    ir = '0;
    @(posedge clk);
    @(negedge clk);
    cyc_check("reset", z);
    clr = 0;
    start = 0;
    @(negedge clk);
    cyc_check("idle", z);
    run(32'h01890000, 0, -1);
    run(32'h4927FFFB, 0, -1);
    run(32'h72B00000, 0, -1);
    run(32'hF8000000, 0, -1);
    run(32'h01890000, 0, 4);
    for (int i = 0; i < 8; i++) run(rand_instr(), 1, -1);
    start = 0;
    @(negedge clk);
    cyc_check("hold_end", z);
    for (int i = 0; i < 80; i++) begin
      run(rand_instr(), 0, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1);
      start = 0;
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        @(negedge clk);
        cyc_check("gap", z);
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
